fpu_resp_queue: RTL and testbench

Response-side companion to `fpnew_top`: it receives the FPU's `out_valid`/`out_ready` result stream and buffers result, status and tag in a small FIFO for a downstream consumer. It also gates the issue side (`in_valid`/`in_ready`) with a credit counter, so the FPU is never stalled by a full response path. The block sits between an issuing master and `fpnew_top`, configured as `DEFAULT_NOREGS` or pipelined. It also accumulates sticky IEEE exception flags.

---
 rtl/fpu_resp_pkg.sv | 27 ++
 rtl/fpu_resp_fifo.sv | 57 +++++
 rtl/fpu_resp_queue.sv | 101 ++++++++++
 tb/tb_fpu_resp_queue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_resp_pkg.sv
// Shared types and helpers for the FPU response queue.
package fpu_resp_pkg;

   localparam int unsigned STATUS_W  = 5;
   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_TAG_W = 1;

   // IEEE exception flags, same ordering as the FPU status word
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] result;
      status_t              status;
      logic [DEF_TAG_W-1:0] tag;
   } rsp_entry_t;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fpu_resp_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous flush.
module fpu_resp_fifo
   import fpu_resp_pkg::*;
#(
   parameter int unsigned DATA_W = 22,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [DATA_W-1:0]            data_i,
   input  logic                         pop_i,
   output logic [DATA_W-1:0]            data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [cnt_width(DEPTH)-1:0]  count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = cnt_width(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, rptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              push_ok, pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + PTR_W'(1);
         end
         if (pop_ok) rptr_q <= rptr_q + PTR_W'(1);
         if (push_ok & ~pop_ok)      cnt_q <= cnt_q + CNT_W'(1);
         else if (pop_ok & ~push_ok) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fpu_resp_queue.sv
// Response buffer for an FPU result stream with credit-gated issue and
// sticky exception flags.
module fpu_resp_queue
   import fpu_resp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = DEF_TAG_W
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   output logic                         fpu_in_valid_o,
   input  logic                         fpu_in_ready_i,
   input  logic                         fpu_out_valid_i,
   output logic                         fpu_out_ready_o,
   input  logic [WIDTH-1:0]             fpu_result_i,
   input  logic [STATUS_W-1:0]          fpu_status_i,
   input  logic [TAG_W-1:0]             fpu_tag_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [WIDTH-1:0]             rsp_result_o,
   output logic [STATUS_W-1:0]          rsp_status_o,
   output logic [TAG_W-1:0]             rsp_tag_o,
   output logic [STATUS_W-1:0]          fflags_o,
   input  logic                         clr_flags_i,
   output logic [cnt_width(DEPTH)-1:0]  outstanding_o,
   output logic                         overflow_o,
   output logic                         busy_o
);

   localparam int unsigned CNT_W   = cnt_width(DEPTH);
   localparam int unsigned ENTRY_W = WIDTH + STATUS_W + TAG_W;

   logic [CNT_W-1:0]    outstanding_q, fifo_cnt;
   logic [ENTRY_W-1:0]  wr_entry, rd_entry;
   logic [STATUS_W-1:0] head_status, fflags_q, fflags_d;
   logic                credit, issue_ev, pop_ev, fifo_full, fifo_empty, overflow_q;

   // Issue side: purely combinational off the registered credit count
   assign credit         = (outstanding_q < CNT_W'(DEPTH));
   assign fpu_in_valid_o = issue_valid_i & credit;
   assign issue_ready_o  = fpu_in_ready_i & credit;
   assign issue_ev       = fpu_in_valid_o & fpu_in_ready_i & ~flush_i;

   assign rsp_valid_o     = ~fifo_empty;
   assign pop_ev          = rsp_valid_o & rsp_ready_i & ~flush_i;
   assign fpu_out_ready_o = (fifo_cnt < CNT_W'(DEPTH));

   assign wr_entry = {fpu_result_i, fpu_status_i, fpu_tag_i};
   assign {rsp_result_o, head_status, rsp_tag_o} = rd_entry;
   assign rsp_status_o = head_status;

   fpu_resp_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (fpu_out_valid_i),
      .data_i  (wr_entry),
      .pop_i   (pop_ev),
      .data_o  (rd_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // Clear applies before the popped status is merged in
   always_comb begin
      fflags_d = clr_flags_i ? '0 : fflags_q;
      if (pop_ev) fflags_d = fflags_d | head_status;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         overflow_q    <= 1'b0;
         fflags_q      <= '0;
      end else begin
         fflags_q <= fflags_d;
         if (flush_i) begin
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
         end else begin
            if (issue_ev & ~pop_ev)      outstanding_q <= outstanding_q + CNT_W'(1);
            else if (pop_ev & ~issue_ev) outstanding_q <= outstanding_q - CNT_W'(1);
            if (fpu_out_valid_i & fifo_full) overflow_q <= 1'b1;
         end
      end
   end

   assign outstanding_o = outstanding_q;
   assign overflow_o    = overflow_q;
   assign fflags_o      = fflags_q;
   assign busy_o        = (outstanding_q != '0);

endmodule

// File: tb/tb_fpu_resp_queue.sv
// Directed bench for fpu_resp_queue with a one-cycle-latency FPU model.
module tb_fpu_resp_queue;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 1;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        flush_i = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic        issue_ready_o;
   logic        fpu_in_valid_o;
   logic        fpu_in_ready_i = 1'b0;
   logic        fpu_out_valid_i = 1'b0;
   logic        fpu_out_ready_o;
   logic [15:0] fpu_result_i = '0;
   logic [4:0]  fpu_status_i = '0;
   logic [0:0]  fpu_tag_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [15:0] rsp_result_o;
   logic [4:0]  rsp_status_o;
   logic [0:0]  rsp_tag_o;
   logic [4:0]  fflags_o;
   logic        clr_flags_i = 1'b0;
   logic [2:0]  outstanding_o;
   logic        overflow_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] op_res [64];
   logic [4:0]  op_sts [64];
   int          iss_n = 0;
   int          exp_idx = 0;
   bit          model_en = 1'b1;
   logic        fire;

   always #5 clk = ~clk;

   fpu_resp_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .issue_valid_i   (issue_valid_i),
      .issue_ready_o   (issue_ready_o),
      .fpu_in_valid_o  (fpu_in_valid_o),
      .fpu_in_ready_i  (fpu_in_ready_i),
      .fpu_out_valid_i (fpu_out_valid_i),
      .fpu_out_ready_o (fpu_out_ready_o),
      .fpu_result_i    (fpu_result_i),
      .fpu_status_i    (fpu_status_i),
      .fpu_tag_i       (fpu_tag_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_result_o    (rsp_result_o),
      .rsp_status_o    (rsp_status_o),
      .rsp_tag_o       (rsp_tag_o),
      .fflags_o        (fflags_o),
      .clr_flags_i     (clr_flags_i),
      .outstanding_o   (outstanding_o),
      .overflow_o      (overflow_o),
      .busy_o          (busy_o)
   );

   // FPU stand-in: result for an issue accepted at edge N is presented after edge N
   always @(posedge clk) begin
      fire = fpu_in_valid_o & fpu_in_ready_i;
      #1;
      if (model_en) begin
         fpu_out_valid_i = fire;
         if (fire) begin
            fpu_result_i = op_res[iss_n];
            fpu_status_i = op_sts[iss_n];
            fpu_tag_i    = 1'(iss_n & 1);
            iss_n++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag);
      check_eq({tag, "_result"}, 32'(rsp_result_o), 32'(op_res[exp_idx]));
      check_eq({tag, "_status"}, 32'(rsp_status_o), 32'(op_sts[exp_idx]));
      check_eq({tag, "_tag"}, 32'(rsp_tag_o), 32'(exp_idx & 1));
   endtask

   // Issue one op, let it land, then pop it (optionally clearing flags that cycle)
   task automatic one_op(input bit clr);
      issue_valid_i = 1'b1;
      #1;
      check_eq("one_issue_ready", 32'(issue_ready_o), 32'd1);
      tick();
      issue_valid_i = 1'b0;
      tick();
      #1;
      check_eq("one_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check_head("one_head");
      rsp_ready_i = 1'b1;
      clr_flags_i = clr;
      tick();
      rsp_ready_i = 1'b0;
      clr_flags_i = 1'b0;
      exp_idx++;
      #1;
   endtask

   int pulses;
   int rcvd;

   initial begin
      for (int k = 0; k < 64; k++) begin
         op_res[k] = 16'(16'h0101 * (k + 1));
         op_sts[k] = '0;
      end
      op_res[0] = 16'h4000;

      // Reset values
      #1 rst_ni = 1'b0;
      #2;
      check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check_eq("rst_out_ready", 32'(fpu_out_ready_o), 32'd1);
      check_eq("rst_issue_ready", 32'(issue_ready_o), 32'd0);
      check_eq("rst_in_valid", 32'(fpu_in_valid_o), 32'd0);
      check_eq("rst_outstanding", 32'(outstanding_o), 32'd0);
      check_eq("rst_fflags", 32'(fflags_o), 32'd0);
      check_eq("rst_overflow", 32'(overflow_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_result", 32'(rsp_result_o), 32'd0);
      #10;
      rst_ni = 1'b1;
      fpu_in_ready_i = 1'b1;
      tick();

      // 1.0 + 1.0 in FP16
      issue_valid_i = 1'b1;
      #1;
      check_eq("add_issue_ready", 32'(issue_ready_o), 32'd1);
      check_eq("add_in_valid", 32'(fpu_in_valid_o), 32'd1);
      tick();
      issue_valid_i = 1'b0;
      #1;
      check_eq("add_outstanding", 32'(outstanding_o), 32'd1);
      check_eq("add_busy", 32'(busy_o), 32'd1);
      check_eq("add_no_bypass", 32'(rsp_valid_o), 32'd0);
      tick();
      #1;
      check_eq("add_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check_eq("add_result", 32'(rsp_result_o), 32'h4000);
      check_eq("add_status", 32'(rsp_status_o), 32'd0);
      check_eq("add_tag", 32'(rsp_tag_o), 32'd0);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      exp_idx++;
      #1;
      check_eq("add_outstanding_done", 32'(outstanding_o), 32'd0);
      check_eq("add_rsp_empty", 32'(rsp_valid_o), 32'd0);

      // Credit limit: 6 requests with consumer stalled
      rsp_ready_i = 1'b0;
      issue_valid_i = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (issue_ready_o) pulses++;
         tick();
      end
      #1;
      check_eq("credit_pulses", 32'(pulses), 32'd4);
      check_eq("credit_in_valid", 32'(fpu_in_valid_o), 32'd0);
      check_eq("credit_outstanding", 32'(outstanding_o), 32'd4);
      check_eq("credit_out_ready_full", 32'(fpu_out_ready_o), 32'd0);
      check_head("credit_head");
      rsp_ready_i = 1'b1;
      rcvd = 0;
      for (int i = 0; i < 30 && rcvd < 6; i++) begin
         #1;
         if (rsp_valid_o) begin
            check_head("credit_rsp");
            rcvd++;
            exp_idx++;
         end
         if (issue_valid_i && issue_ready_o) pulses++;
         tick();
         if (pulses == 6) issue_valid_i = 1'b0;
      end
      #1;
      check_eq("credit_rcvd", 32'(rcvd), 32'd6);
      check_eq("credit_issued", 32'(pulses), 32'd6);
      check_eq("credit_drained", 32'(outstanding_o), 32'd0);

      // Sustained throughput with pointer wrap
      issue_valid_i = 1'b1;
      rsp_ready_i = 1'b1;
      rcvd = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (rsp_valid_o) begin
            check_head("stream_rsp");
            rcvd++;
            exp_idx++;
         end
         if (i >= 2) check_eq("stream_outstanding", 32'(outstanding_o), 32'd2);
         tick();
      end
      issue_valid_i = 1'b0;
      check_eq("stream_rate", 32'(rcvd), 32'd14);
      for (int i = 0; i < 6; i++) begin
         #1;
         if (rsp_valid_o) begin
            check_head("stream_drain");
            rcvd++;
            exp_idx++;
         end
         tick();
      end
      #1;
      check_eq("stream_total", 32'(rcvd), 32'd16);
      check_eq("stream_idle", 32'(outstanding_o), 32'd0);
      rsp_ready_i = 1'b0;

      // Sticky flags: 0x7BFF+0x7BFF overflows to +inf with OF|NX
      op_res[iss_n]     = 16'h7C00;
      op_sts[iss_n]     = 5'b00101;
      op_sts[iss_n + 2] = 5'b10000;
      one_op(1'b0);
      check_eq("flags_after_of", 32'(fflags_o), 32'b00101);
      one_op(1'b0);
      check_eq("flags_sticky", 32'(fflags_o), 32'b00101);
      one_op(1'b1);
      check_eq("flags_clr_and_pop", 32'(fflags_o), 32'b10000);
      clr_flags_i = 1'b1;
      tick();
      clr_flags_i = 1'b0;
      #1;
      check_eq("flags_cleared", 32'(fflags_o), 32'd0);

      // Overflow: write into a full FIFO is dropped
      issue_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      issue_valid_i = 1'b0;
      model_en = 1'b0;
      #1;
      check_eq("ovf_full", 32'(fpu_out_ready_o), 32'd0);
      tick();
      fpu_out_valid_i = 1'b1;
      fpu_result_i = 16'hDEAD;
      fpu_status_i = 5'b11111;
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("ovf_flag", 32'(overflow_o), 32'd1);
      check_eq("ovf_outstanding", 32'(outstanding_o), 32'd4);
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check_head("ovf_keep");
         tick();
         exp_idx++;
         #1;
      end
      rsp_ready_i = 1'b0;
      check_eq("ovf_still_set", 32'(overflow_o), 32'd1);
      check_eq("ovf_flags_untouched", 32'(fflags_o), 32'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      check_eq("flush_overflow", 32'(overflow_o), 32'd0);
      check_eq("flush_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check_eq("flush_outstanding", 32'(outstanding_o), 32'd0);
      check_eq("flush_out_ready", 32'(fpu_out_ready_o), 32'd1);
      model_en = 1'b1;
      exp_idx = iss_n;

      // Reset with 3 queued and 1 in flight
      issue_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      issue_valid_i = 1'b0;
      #1;
      check_eq("mid_pre_outstanding", 32'(outstanding_o), 32'd4);
      check_eq("mid_pre_valid", 32'(rsp_valid_o), 32'd1);
      rst_ni = 1'b0;
      model_en = 1'b0;
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
      check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
      check_eq("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
      check_eq("mid_rst_out_ready", 32'(fpu_out_ready_o), 32'd1);
      #2;
      rst_ni = 1'b1;
      model_en = 1'b1;
      exp_idx = iss_n;
      tick();
      one_op(1'b0);
      check_eq("post_rst_outstanding", 32'(outstanding_o), 32'd0);
      check_eq("post_rst_empty", 32'(rsp_valid_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
